// File: rtl/gpio_pkg.sv
// Shared definitions for the byte-wide digital I/O port: register offsets,
// default base addresses and the interrupt-vector encoder.
package gpio_pkg;

    localparam logic [15:0] P1_BASE = 16'h0200;
    localparam logic [15:0] P2_BASE = 16'h0220;

    localparam logic [4:0] OFF_IN   = 5'h00;
    localparam logic [4:0] OFF_OUT  = 5'h02;
    localparam logic [4:0] OFF_DIR  = 5'h04;
    localparam logic [4:0] OFF_REN  = 5'h06;
    localparam logic [4:0] OFF_SEL0 = 5'h0A;
    localparam logic [4:0] OFF_SEL1 = 5'h0C;
    localparam logic [4:0] OFF_IV   = 5'h0E;
    localparam logic [4:0] OFF_SELC = 5'h16;
    localparam logic [4:0] OFF_IES  = 5'h18;
    localparam logic [4:0] OFF_IE   = 5'h1A;
    localparam logic [4:0] OFF_IFG  = 5'h1C;

    // 2*(n+1) for the lowest set bit n, 0 when nothing is pending.
    function automatic logic [7:0] iv_encode(input logic [7:0] pend);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (pend[i]) v = 8'((i + 1) * 2);
        end
        return v;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin input synchroniser with IES-qualified edge detection; detection stays
// disarmed until the synchroniser has flushed after reset.
module gpio_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pin_in,
    input  logic [7:0] ies,
    output logic [7:0] sync_in,
    output logic [7:0] edge_det
);

    localparam int CW = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_LOAD = CW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][7:0] sync_q, sync_d;
    logic [7:0]                  prev_q, prev_d;
    logic [CW-1:0]               arm_cnt_q, arm_cnt_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = pin_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        sync_in   = sync_q[SYNC_STAGES-1];
        prev_d    = sync_in;
        arm_cnt_d = (arm_cnt_q != '0) ? arm_cnt_q - 1'b1 : arm_cnt_q;
        // Changed bit whose new level differs from IES: rise when IES=0, fall when IES=1.
        edge_det  = (arm_cnt_q == '0) ? ((sync_in ^ prev_q) & (sync_in ^ ies)) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            prev_q    <= '0;
            arm_cnt_q <= ARM_LOAD;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

endmodule

// File: rtl/gpio_port.sv
// Digital I/O port register block: bus decode, port registers, edge flags
// and the interrupt vector with bit-0-first priority.
module gpio_port
    import gpio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = P1_BASE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    input  logic [7:0]  pin_in,
    output logic [7:0]  PxOUT,
    output logic [7:0]  PxDIR,
    output logic [7:0]  PxREN,
    output logic [7:0]  PxSEL0,
    output logic [7:0]  PxSEL1,
    output logic        irq
);

    logic [7:0]  out_q, out_d, dir_q, dir_d, ren_q, ren_d;
    logic [7:0]  sel0_q, sel0_d, sel1_q, sel1_d;
    logic [7:0]  ies_q, ies_d, ie_q, ie_d, ifg_q, ifg_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] off_full;
    logic [4:0]  off;
    logic        in_win, wr_en, rd_en;
    logic [7:0]  pending, low_mask, iv_val;
    logic [7:0]  sync_in, edge_det;

    gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
        .clk      (MCLK),
        .rst      (RST),
        .pin_in   (pin_in),
        .ies      (ies_q),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    always_comb begin
        off_full = addr - BASE_ADDR;
        in_win   = (off_full < 16'd32);
        off      = off_full[4:0];
        wr_en    = we & in_win;
        rd_en    = re & in_win;
        pending  = ifg_q & ie_q;
        low_mask = pending & (~pending + 8'd1);
        iv_val   = iv_encode(pending);

        out_d  = out_q;
        dir_d  = dir_q;
        ren_d  = ren_q;
        sel0_d = sel0_q;
        sel1_d = sel1_q;
        ies_d  = ies_q;
        ie_d   = ie_q;
        ifg_d  = ifg_q;

        if (rd_en && off == OFF_IV) ifg_d = ifg_q & ~low_mask;

        if (wr_en) begin
            case (off)
                OFF_OUT:  out_d  = wdata;
                OFF_DIR:  dir_d  = wdata;
                OFF_REN:  ren_d  = wdata;
                OFF_SEL0: sel0_d = wdata;
                OFF_SEL1: sel1_d = wdata;
                OFF_SELC: begin
                    sel0_d = sel0_q ^ wdata;
                    sel1_d = sel1_q ^ wdata;
                end
                OFF_IES:  ies_d  = wdata;
                OFF_IE:   ie_d   = wdata;
                OFF_IFG:  ifg_d  = wdata;
                OFF_IV:   ifg_d  = 8'h00;
                default:  ;
            endcase
        end

        // Hardware edges override any software clear in the same cycle.
        ifg_d = ifg_d | edge_det;

        rdata_d = 8'h00;
        if (rd_en) begin
            case (off)
                OFF_IN:   rdata_d = sync_in;
                OFF_OUT:  rdata_d = out_q;
                OFF_DIR:  rdata_d = dir_q;
                OFF_REN:  rdata_d = ren_q;
                OFF_SEL0: rdata_d = sel0_q;
                OFF_SEL1: rdata_d = sel1_q;
                OFF_IV:   rdata_d = iv_val;
                OFF_IES:  rdata_d = ies_q;
                OFF_IE:   rdata_d = ie_q;
                OFF_IFG:  rdata_d = ifg_q;
                default:  rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            out_q   <= '0;
            dir_q   <= '0;
            ren_q   <= '0;
            sel0_q  <= '0;
            sel1_q  <= '0;
            ies_q   <= '0;
            ie_q    <= '0;
            ifg_q   <= '0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ren_q   <= ren_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            ies_q   <= ies_d;
            ie_q    <= ie_d;
            ifg_q   <= ifg_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata  = rdata_q;
    assign PxOUT  = out_q;
    assign PxDIR  = dir_q;
    assign PxREN  = ren_q;
    assign PxSEL0 = sel0_q;
    assign PxSEL1 = sel1_q;
    assign irq    = |(ifg_q & ie_q);

endmodule

// File: doc/gpio_port.md
Name: gpio_port

Overview:
- Byte-wide MSP430 digital I/O port register block, one instance per port (P1, P2, ...).
- Drives the per-pin mux stage with OUT/DIR/REN/SEL and takes the raw pin input back from it.
- Synchronises pin inputs and detects edges into PxIFG; presents PxIV and an interrupt request to the CPU.
- Sits on the peripheral memory bus.

Parameters:
- BASE_ADDR, 16'h0200, byte address of PxIN; the port occupies BASE_ADDR .. BASE_ADDR+0x1F.
- SYNC_STAGES, 2, flip-flop stages on pin inputs (minimum 2).

Ports:
- MCLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- addr  in  16  byte address from the CPU bus.
- wdata  in  8  write data.
- we  in  1  write strobe, one cycle per access.
- re  in  1  read strobe, one cycle per access.
- rdata  out  8  read data.
- pin_in  in  8  raw PxINm from the 8 pin-mux instances (asynchronous).
- PxOUT  out  8  output latch, to pin mux.
- PxDIR  out  8  direction (1 = output).
- PxREN  out  8  pull enable.
- PxSEL0  out  8  function select bit 0 (PxSELm[0] of each pin).
- PxSEL1  out  8  function select bit 1 (PxSELm[1] of each pin).
- irq  out  1  OR of (PxIFG & PxIE).

Behaviour:
- Register map (offsets from BASE_ADDR):
  - 0x00 IN, read-only.
  - 0x02 OUT, 0x04 DIR, 0x06 REN, 0x0A SEL0, 0x0C SEL1: read/write.
  - 0x0E IV.
  - 0x16 SELC, write-only, reads as 0.
  - 0x18 IES, 0x1A IE, 0x1C IFG: read/write.
  - Unmapped offsets in the window read 0; writes to them are ignored.
  - Addresses outside the window: no read or write effect.
- Reset: every register and output is 0, including rdata, irq and the sync flops.
- Reads: rdata is registered and valid the cycle after re is high with a decoded address; it is 0 in all other cycles. Simultaneous we and re: the write takes effect and rdata returns the pre-write value.
- IN read returns the synchronised value, i.e. pin_in delayed by SYNC_STAGES cycles.
- SELC write: SEL0 ^= wdata and SEL1 ^= wdata, in the same cycle.
- Edge detect, per bit, on the synchronised input:
  - IES=0: flag on rising edge; IES=1: flag on falling edge.
  - Sets IFG whether or not IE is set.
  - Writing IES does not set IFG.
- Edge arming: detection is suppressed until SYNC_STAGES+1 cycles after RST deasserts, so pins that are high at reset do not set IFG.
- IFG write: IFG <= wdata. If a hardware edge on a bit coincides with the write, that bit ends at 1 (set wins).
- IV read:
  - Returns 2*(n+1), where n is the lowest bit set in IFG & IE; returns 0 if none.
  - The same cycle, clears IFG[n] unless an edge on bit n coincides (set wins).
  - Priority: bit 0 highest.
- IV write: clears all IFG bits not being set by a coincident edge.
- irq: combinational from the IFG and IE registers, so it updates the cycle after a flag change.
- RST mid-operation: everything returns to reset values and edge arming restarts.

Decomposition:
- Shared package (gpio_pkg): register offset constants, IV encoding function, default BASE_ADDR per port.
- Sub-module gpio_sync_edge:
  - SYNC_STAGES synchroniser, previous-value register, arming counter, IES-qualified edge pulse.
  - Outputs sync_in[7:0] and edge[7:0].
- Top level: bus decode, registers, IV priority encoder.

Test Plan:
- Reset/readback: after RST, write OUT=8'hA5, DIR=8'h0F, SEL0=8'h03, then SELC=8'h01. Read back OUT=A5, DIR=0F, SEL0=02, SEL1=01. Pin outputs match the same cycle after each write.
- Rising edge: IES=0, IE=8'h08, pin_in[3] goes 0->1. IFG[3] is set and irq=1 exactly SYNC_STAGES+1 cycles after the pin change. IN reads 8'h08.
- IV priority: set IFG=8'h24 by write with IE=8'hFF. First IV read returns 6 and clears bit 2; second returns 12 and clears bit 5; third returns 0 and irq=0.
- Falling edge with IE=0: IES[7]=1, pin 1->0. IFG[7]=1, irq stays 0, IV reads 0.
- Set wins: an IFG write of 0 lands in the same cycle as a rising edge on bit 1. IFG reads 8'h02.
- Reset arming: hold pin_in=8'hFF through RST release. IFG stays 0 for 10 cycles after release.
